uart_rx: RTL and testbench



---
 rtl/uart_pkg.sv | 8 +
 rtl/ram_for_uart_rx.sv | 30 +++
 rtl/uart_rx.sv | 149 ++++++++++++++
 tb/tb_uart_rx.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} uart_rx_state_t;

endpackage

// File: rtl/ram_for_uart_rx.sv
// Simple dual-port RAM (one write port, one read port) with a registered read port.
module ram_for_uart_rx #(
  parameter int ADDR_LEN = 9,
  parameter int DATA_LEN = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [ADDR_LEN-1:0] waddr,
  input  logic [DATA_LEN-1:0] wdata,
  input  logic                re,
  input  logic [ADDR_LEN-1:0] raddr,
  output logic [DATA_LEN-1:0] rdata
);

  logic [DATA_LEN-1:0] mem [2**ADDR_LEN];

  // NOTE: the storage array is deliberately not reset, so it can map onto block RAM;
  // the pointers in the parent decide which entries are meaningful.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // The read register doubles as the consumer-facing data register, so it resets to 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizer, mid-bit sampling FSM, RAM FIFO and a
// valid/ready output whose data register is the RAM read register.
module uart_rx
  import uart_pkg::*;
#(
  parameter int UART_CLK_DIV = 434,
  parameter int FIFO_ASIZE   = 9
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_uart_rx,
  output logic                      rvalid,
  input  logic                      rready,
  output logic [UART_DATA_BITS-1:0] rdata,
  output logic                      frame_err,
  output logic                      overflow
);

  localparam int CYC_W = $clog2(UART_CLK_DIV);
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(UART_CLK_DIV - 1);
  localparam logic [CYC_W-1:0] CYC_HALF = CYC_W'(UART_CLK_DIV / 2 - 1);
  localparam logic [2:0]       BIT_LAST = 3'(UART_DATA_BITS - 1);

  logic rx_m, rx_s;

  uart_rx_state_t            state_q, state_d;
  logic [CYC_W-1:0]          cyc_q, cyc_d;
  logic [2:0]                bitcnt_q, bitcnt_d;
  logic [UART_DATA_BITS-1:0] shreg_q, shreg_d;
  logic                      push_q, push_d, ferr_d, ovf_d;

  logic [FIFO_ASIZE-1:0] wp, rp, wp_inc;
  logic                  empty, full, rd_en, rd_inflight;

  // NOTE: every sequential process in this design uses non-blocking assignments only,
  // so all flops update together from the values present before the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= i_uart_rx;
      rx_s <= rx_m;
    end
  end

  // NOTE: every output of this block gets a default before the case, so no latch can form.
  always_comb begin
    state_d  = state_q;
    cyc_d    = cyc_q + 1'b1;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    push_d   = 1'b0;
    ferr_d   = 1'b0;
    ovf_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        cyc_d = '0;
        if (!rx_s) state_d = START;
      end
      START: if (cyc_q == CYC_HALF) begin
        cyc_d    = '0;
        bitcnt_d = '0;
        state_d  = rx_s ? IDLE : DATA;
      end
      DATA: if (cyc_q == CYC_LAST) begin
        cyc_d    = '0;
        shreg_d  = {rx_s, shreg_q[UART_DATA_BITS-1:1]};
        bitcnt_d = bitcnt_q + 1'b1;
        if (bitcnt_q == BIT_LAST) state_d = STOP;
      end
      STOP: if (cyc_q == CYC_LAST) begin
        cyc_d = '0;
        if (rx_s) begin
          // Leave at the stop-bit midpoint so a back-to-back start edge is not missed.
          state_d = IDLE;
          push_d  = !full;
          ovf_d   = full;
        end else begin
          state_d = BREAK;
          ferr_d  = 1'b1;
        end
      end
      BREAK: begin
        cyc_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cyc_q     <= '0;
      bitcnt_q  <= '0;
      shreg_q   <= '0;
      push_q    <= 1'b0;
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      bitcnt_q  <= bitcnt_d;
      shreg_q   <= shreg_d;
      push_q    <= push_d;
      frame_err <= ferr_d;
      overflow  <= ovf_d;
    end
  end

  assign wp_inc = wp + 1'b1;
  assign empty  = (wp == rp);
  assign full   = (wp_inc == rp);

  // One read per two cycles at most: the cycle after a read is blocked while it lands.
  assign rd_en = !empty && (!rvalid || rready) && !rd_inflight;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp          <= '0;
      rp          <= '0;
      rvalid      <= 1'b0;
      rd_inflight <= 1'b0;
    end else begin
      if (push_q) wp <= wp_inc;
      if (rd_en)  rp <= rp + 1'b1;
      rd_inflight <= rd_en;
      if (rd_en)       rvalid <= 1'b1;
      else if (rready) rvalid <= 1'b0;
    end
  end

  // shreg_q is stable in the push cycle: the next frame cannot reach DATA that soon.
  ram_for_uart_rx #(
    .ADDR_LEN(FIFO_ASIZE),
    .DATA_LEN(UART_DATA_BITS)
  ) u_ram (
    .clk  (clk),
    .rst  (rst),
    .we   (push_q),
    .waddr(wp),
    .wdata(shreg_q),
    .re   (rd_en),
    .raddr(rp),
    .rdata(rdata)
  );

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed table, hand-written corner sequences,
// and randomized frames checked against a byte-queue model of the serial protocol.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int DIV = 8;
  localparam int ASZ = 2;
  localparam int T   = 10;
  // Pin-low cycle to rvalid rise: 2 sync + half bit + 9 bits + 3 FIFO/output cycles.
  localparam int RISE_CYC = 2 + DIV / 2 + 9 * DIV + 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_uart_rx = 1'b1;
  logic       rready = 1'b1;
  logic       rvalid, frame_err, overflow;
  logic [7:0] rdata;

  always #(T / 2) clk = ~clk;

  uart_rx #(.UART_CLK_DIV(DIV), .FIFO_ASIZE(ASZ)) dut (
    .clk      (clk),
    .rst      (rst),
    .i_uart_rx(i_uart_rx),
    .rvalid   (rvalid),
    .rready   (rready),
    .rdata    (rdata),
    .frame_err(frame_err),
    .overflow (overflow)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: transfers, rvalid rise times and pulse-cycle counts, sampled on negedge.
  logic [7:0] got_q[$];
  longint     rise_q[$];
  int         fe_cnt = 0, ov_cnt = 0, vhi_cnt = 0;
  logic       rv_prev = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (rvalid && rready) got_q.push_back(rdata);
      if (rvalid && !rv_prev) rise_q.push_back($time);
      if (frame_err) fe_cnt <= fe_cnt + 1;
      if (overflow)  ov_cnt <= ov_cnt + 1;
      if (rvalid)    vhi_cnt <= vhi_cnt + 1;
    end
    rv_prev <= rvalid;
  end

  int gi = 0;

  task automatic expect_byte(input string name, input logic [7:0] exp);
    if (gi < got_q.size()) begin
      check(name, got_q[gi], exp);
      gi++;
    end else begin
      check({name, " (missing)"}, -1, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic set_line(input logic v, input int cycles);
    @(posedge clk);
    #1 i_uart_rx = v;
    repeat (cycles - 1) @(posedge clk);
  endtask

  longint t_start;

  // Start bit, 8 data bits LSB first, optional low stop of stop_low bit times, then a high bit.
  task automatic send_frame(input logic [7:0] d, input int stop_low);
    @(posedge clk);
    #1 i_uart_rx = 1'b0;
    t_start = $time - 1;
    repeat (DIV - 1) @(posedge clk);
    for (int k = 0; k < 8; k++) set_line(d[k], DIV);
    if (stop_low > 0) set_line(1'b0, stop_low * DIV);
    set_line(1'b1, DIV);
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge clk);
    check({tag, " rvalid"}, rvalid, 0);
    check({tag, " rdata"}, rdata, 0);
    check({tag, " frame_err"}, frame_err, 0);
    check({tag, " overflow"}, overflow, 0);
  endtask

  typedef struct {
    logic [7:0] data;
    int         stop_low;
    int         gap;
    bit         deliver;
  } vec_t;

  vec_t       vecs[6];
  logic [7:0] exp_q[$];
  bit         rand_rdy = 1'b0;

  initial begin
    int fe0, ov0, n0, exp_fe;
    longint exp_rise;

    // Reset state
    check_reset_outputs("reset");
    idle(2);
    #1 rst = 1'b0;
    idle(4);

    // Single frame 0x55 with latency check
    fe0 = fe_cnt; ov0 = ov_cnt; n0 = vhi_cnt;
    send_frame(8'h55, 0);
    exp_rise = t_start + longint'(RISE_CYC * T + T / 2);
    idle(20);
    expect_byte("single data", 8'h55);
    check("single count", got_q.size(), 1);
    check("single rise time", (rise_q.size() > 0) ? rise_q[0] : -1, exp_rise);
    check("single rvalid cycles", vhi_cnt - n0, 1);
    check("single frame_err", fe_cnt - fe0, 0);
    check("single overflow", ov_cnt - ov0, 0);

    // Glitch: 3-cycle low pulse is rejected
    fe0 = fe_cnt; ov0 = ov_cnt; n0 = got_q.size();
    @(posedge clk);
    #1 i_uart_rx = 1'b0;
    idle(3);
    #1 i_uart_rx = 1'b1;
    idle(30);
    check("glitch bytes", got_q.size(), n0);
    check("glitch frame_err", fe_cnt - fe0, 0);
    check("glitch overflow", ov_cnt - ov0, 0);
    check("glitch state idle", int'(dut.state_q), int'(IDLE));

    // Table: back-to-back burst, framing error with held-low stop, recovery byte
    vecs = '{
      '{8'h00, 0, 0, 1'b1},
      '{8'hFF, 0, 0, 1'b1},
      '{8'hA5, 0, 0, 1'b1},
      '{8'h3C, 0, 0, 1'b1},
      '{8'h81, 2, 5, 1'b0},
      '{8'h42, 0, 0, 1'b1}
    };
    fe0 = fe_cnt; ov0 = ov_cnt; exp_fe = 0;
    for (int i = 0; i < 6; i++) begin
      idle(vecs[i].gap);
      send_frame(vecs[i].data, vecs[i].stop_low);
      if (vecs[i].stop_low > 0) exp_fe++;
    end
    idle(40);
    for (int i = 0; i < 6; i++)
      if (vecs[i].deliver) expect_byte($sformatf("table[%0d]", i), vecs[i].data);
    check("table extra bytes", got_q.size(), gi);
    check("table frame_err", fe_cnt - fe0, exp_fe);
    check("table overflow", ov_cnt - ov0, 0);

    // Overflow: 4 bytes of storage, 5th byte dropped; rdata held while stalled
    fe0 = fe_cnt; ov0 = ov_cnt;
    @(posedge clk);
    #1 rready = 1'b0;
    idle(5);
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 0);
    idle(20);
    check("ovf pulse", ov_cnt - ov0, 1);
    check("ovf frame_err", fe_cnt - fe0, 0);
    @(negedge clk);
    check("ovf stall rvalid", rvalid, 1);
    check("ovf stall rdata", rdata, 8'h01);
    idle(50);
    @(negedge clk);
    check("ovf hold rvalid", rvalid, 1);
    check("ovf hold rdata", rdata, 8'h01);
    @(posedge clk);
    #1 rready = 1'b1;
    idle(40);
    for (int i = 1; i <= 4; i++) expect_byte($sformatf("ovf drain %0d", i), 8'(i));
    check("ovf extra bytes", got_q.size(), gi);

    // Reset mid-frame with bytes buffered: nothing stale survives
    @(posedge clk);
    #1 rready = 1'b0;
    send_frame(8'h99, 0);
    send_frame(8'h66, 0);
    idle(20);
    @(posedge clk);
    #1 i_uart_rx = 1'b0;
    repeat (DIV - 1) @(posedge clk);
    for (int k = 0; k < 4; k++) set_line(k[0], DIV);
    set_line(1'b0, 3);
    #1 rst = 1'b1;
    check_reset_outputs("mid reset");
    idle(5);
    #1 begin
      rst = 1'b0;
      i_uart_rx = 1'b1;
      rready = 1'b1;
    end
    fe0 = fe_cnt; ov0 = ov_cnt;
    idle(2 * DIV);
    send_frame(8'h7E, 0);
    idle(40);
    expect_byte("post reset", 8'h7E);
    check("post reset extra", got_q.size(), gi);
    check("post reset frame_err", fe_cnt - fe0, 0);

    // Randomized frames with random back-pressure against the byte-queue model
    fe0 = fe_cnt; ov0 = ov_cnt; exp_fe = 0;
    rand_rdy = 1'b1;
    fork
      begin
        while (rand_rdy) begin
          @(posedge clk);
          #1 rready = ($urandom_range(0, 9) < 7);
        end
      end
    join_none
    for (int i = 0; i < 24; i++) begin
      logic [7:0] d;
      int sl;
      d  = 8'($urandom);
      sl = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 2)) : 0;
      idle($urandom_range(0, 12));
      send_frame(d, sl);
      if (sl == 0) exp_q.push_back(d);
      else exp_fe++;
    end
    rand_rdy = 1'b0;
    idle(2);
    #1 rready = 1'b1;
    idle(60);
    foreach (exp_q[i]) expect_byte($sformatf("rand[%0d]", i), exp_q[i]);
    check("rand extra bytes", got_q.size(), gi);
    check("rand frame_err", fe_cnt - fe0, exp_fe);
    check("rand overflow", ov_cnt - ov0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
